// File: rtl/steer_en_ctrl.sv
// steer_en_ctrl: rider-detect / steering-enable controller.
// Sums and compares the left/right load cells. Steering is enabled only after
// the rider has stood loaded and balanced for a full qualification timer period.
// Optional macro RIDER_OFF_DEBOUNCE_EN: when defined, a low total load must
// persist for DEBOUNCE_CYC consecutive clocks before the rider is declared off.
module steer_en_ctrl #(
  parameter logic [12:0] MIN_RIDER_WT = 13'h0200,
  parameter logic [12:0] WT_HYST      = 13'h0040,
`ifdef RIDER_OFF_DEBOUNCE_EN
  parameter int          DEBOUNCE_CYC = 256,
`endif
  parameter int          TMR_BITS     = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  output logic        en_steer,
  output logic        rider_off
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, STEER_EN = 2'd2} state_t;

  localparam logic [12:0] SUM_HI = MIN_RIDER_WT + WT_HYST;
  localparam logic [12:0] SUM_LO = MIN_RIDER_WT - WT_HYST;

  state_t              state, nxt_state;
  logic [TMR_BITS-1:0] tmr, nxt_tmr;
  logic [12:0]         sum;
  logic [11:0]         diff;
  logic [16:0]         diff_x16, sum_x15;
  logic                sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16;
  logic                tmr_full, lt_exit;

  // Load arithmetic, all widened so nothing truncates.
  assign sum           = {1'b0, lft_ld} + {1'b0, rght_ld};
  assign diff          = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);
  assign diff_x16      = {1'b0, diff, 4'b0000};
  assign sum_x15       = {sum, 4'b0000} - {4'b0000, sum};
  assign sum_gt_min    = sum > SUM_HI;
  assign sum_lt_min    = sum < SUM_LO;
  assign diff_gt_1_4   = {diff, 2'b00} > {1'b0, sum};
  assign diff_gt_15_16 = diff_x16 > sum_x15;
  assign tmr_full      = &tmr;

`ifdef RIDER_OFF_DEBOUNCE_EN
  logic [7:0] db_cnt, nxt_db;

  // Exit only on the DEBOUNCE_CYC-th consecutive low-load clock.
  assign lt_exit = sum_lt_min && (db_cnt == 8'(DEBOUNCE_CYC - 1));
  assign nxt_db  = (state == IDLE || !sum_lt_min) ? 8'd0 : db_cnt + 8'd1;

  // Consecutive low-load counter.
  always_ff @(posedge clk) begin
    if (!rst_n) db_cnt <= 8'd0;
    else        db_cnt <= nxt_db;
  end
`else
  assign lt_exit = sum_lt_min;
`endif

  // State and qualification timer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      tmr   <= '0;
    end else begin
      state <= nxt_state;
      tmr   <= nxt_tmr;
    end
  end

  // Next-state: rider-off beats imbalance, imbalance beats timer expiry.
  always_comb begin
    nxt_state = state;
    nxt_tmr   = '0;
    case (state)
      IDLE: begin
        if (sum_gt_min) nxt_state = WAIT;
      end
      WAIT: begin
        if (lt_exit)          nxt_state = IDLE;
        else if (diff_gt_1_4) nxt_tmr   = '0;
        else if (tmr_full)    nxt_state = STEER_EN;
        else                  nxt_tmr   = tmr + 1'b1;
      end
      STEER_EN: begin
        if (lt_exit)            nxt_state = IDLE;
        else if (diff_gt_15_16) nxt_state = WAIT;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Moore outputs from the registered state.
  assign rider_off = (state == IDLE);
  assign en_steer  = (state == STEER_EN);

endmodule

// File: tb/tb_steer_en_ctrl.sv
// Bench for steer_en_ctrl: directed test-plan steps plus random load segments,
// each cycle compared against a behavioural model of the rider rules.
module tb_steer_en_ctrl;
  localparam int TB_TMR = 8;
  localparam int QUAL   = 1 << TB_TMR;
  localparam int FULL   = QUAL - 1;
  localparam int DB_CYC = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] lft_ld = '0, rght_ld = '0;
  logic        en_steer, rider_off;

  int checks = 0, errors = 0;
  int m_st = 0, m_tmr = 0, m_db = 0;  // 0 idle, 1 qualifying, 2 steering
  string phase = "init";

  always #5 clk = ~clk;

  steer_en_ctrl #(.TMR_BITS(TB_TMR)) dut (
    .clk(clk), .rst_n(rst_n), .lft_ld(lft_ld), .rght_ld(rght_ld),
    .en_steer(en_steer), .rider_off(rider_off)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
    end
  endtask

  // Behavioural model: one clock of the rider rules using integer arithmetic.
  task automatic model_clk(input int l, input int r, input bit rst);
    int sum, diff, db_next;
    bit gt, lt, imb4, imb15, lt_exit;
    if (rst) begin
      m_st = 0; m_tmr = 0; m_db = 0;
      return;
    end
    sum   = l + r;
    diff  = (l > r) ? l - r : r - l;
    gt    = sum > (512 + 64);
    lt    = sum < (512 - 64);
    imb4  = 4 * diff > sum;
    imb15 = 16 * diff > 15 * sum;
`ifdef RIDER_OFF_DEBOUNCE_EN
    lt_exit = lt && (m_db + 1 >= DB_CYC);
    db_next = (m_st == 0 || !lt) ? 0 : m_db + 1;
`else
    lt_exit = lt;
    db_next = 0;
`endif
    m_db = db_next;
    case (m_st)
      0: if (gt) begin m_st = 1; m_tmr = 0; end
      1: begin
        if (lt_exit)            begin m_st = 0; m_tmr = 0; end
        else if (imb4)          m_tmr = 0;
        else if (m_tmr == FULL) begin m_st = 2; m_tmr = 0; end
        else                    m_tmr++;
      end
      default: begin
        if (lt_exit)    m_st = 0;
        else if (imb15) begin m_st = 1; m_tmr = 0; end
      end
    endcase
    if (m_st == 0) m_db = 0;
  endtask

  // Apply loads for one clock, advance the model, compare outputs after the edge.
  task automatic step(input int l, input int r, input bit rst = 1'b0);
    lft_ld  = 12'(l);
    rght_ld = 12'(r);
    rst_n   = !rst;
    @(posedge clk);
    model_clk(l, r, rst);
    #1;
    chk("rider_off", int'(rider_off), (m_st == 0) ? 1 : 0);
    chk("en_steer",  int'(en_steer),  (m_st == 2) ? 1 : 0);
  endtask

  // Hold loads until en_steer rises (bounded), returning the clock count.
  task automatic clks_to_en(input int l, input int r, output int n);
    n = 0;
    for (int i = 0; i < 2 * QUAL + 10; i++) begin
      step(l, r);
      n++;
      if (en_steer) break;
    end
  endtask

  initial begin
    int n, kind, len, l, r, b;

    // 1: reset and idle with no load.
    phase = "reset";
    step(0, 0, 1'b1);
    chk("rst_rider_off", int'(rider_off), 1);
    chk("rst_en_steer", int'(en_steer), 0);
    phase = "idle_hold";
    repeat (1000) step(0, 0);
    chk("idle_rider_off", int'(rider_off), 1);

    // 2: balanced rider qualifies in exactly 2^TMR_BITS clocks.
    phase = "qualify";
    step(12'h180, 12'h180);
    chk("wait_rider_off", int'(rider_off), 0);
    chk("wait_en_steer", int'(en_steer), 0);
    clks_to_en(12'h180, 12'h180, n);
    chk("qual_latency", n, QUAL);

    // 3: imbalance blip mid-qualification restarts the timer.
    phase = "restart";
    step(0, 0, 1'b1);
    step(12'h180, 12'h180);
    repeat (200) step(12'h180, 12'h180);
    step(12'h200, 12'h0F0);
    chk("imb_stays_wait", int'(rider_off), 0);
    clks_to_en(12'h180, 12'h180, n);
    chk("restart_latency", n, QUAL);

    // 4: heavy imbalance drops steering; moderate imbalance holds in WAIT.
    phase = "imb_15_16";
    step(12'h300, 12'h010);
    chk("drop_en_steer", int'(en_steer), 0);
    chk("drop_rider_off", int'(rider_off), 0);
    repeat (300) step(12'h200, 12'h0F0);
    chk("hold_wait_en", int'(en_steer), 0);
    chk("hold_wait_off", int'(rider_off), 0);

    // 5: in-band load keeps steering; low load exits (debounced if enabled).
    phase = "band";
    clks_to_en(12'h180, 12'h180, n);
    chk("band_qual", n, QUAL);
    repeat (20) step(12'h100, 12'h100);
    chk("band_en_steer", int'(en_steer), 1);
    phase = "low_exit";
`ifdef RIDER_OFF_DEBOUNCE_EN
    step(12'h0C0, 12'h0C0);
    step(12'h180, 12'h180);
    chk("glitch_no_exit", int'(en_steer), 1);
    repeat (DB_CYC - 1) step(12'h0C0, 12'h0C0);
    chk("db_255_still_on", int'(rider_off), 0);
    step(12'h0C0, 12'h0C0);
    chk("db_256_off", int'(rider_off), 1);
`else
    step(12'h0C0, 12'h0C0);
    chk("low_off", int'(rider_off), 1);
    chk("low_en", int'(en_steer), 0);
`endif

    // 6: reset mid-WAIT restarts the full qualification.
    phase = "mid_reset";
    step(12'h180, 12'h180);
    repeat (100) step(12'h180, 12'h180);
    step(12'h180, 12'h180, 1'b1);
    chk("mr_rider_off", int'(rider_off), 1);
    chk("mr_en_steer", int'(en_steer), 0);
    step(12'h180, 12'h180);
    chk("mr_rewait", int'(rider_off), 0);
    clks_to_en(12'h180, 12'h180, n);
    chk("mr_latency", n, QUAL);

    // Random segments of held or jittering loads against the model.
    phase = "random";
    for (int seg = 0; seg < 80; seg++) begin
      kind = $urandom_range(0, 5);
      len  = $urandom_range(1, 320);
      if ($urandom_range(0, 9) == 0) step(0, 0, 1'b1);
      b = $urandom_range(12'h140, 12'h300);
      l = b + $urandom_range(0, 12'h020);
      r = b;
      if (kind == 2) begin l = $urandom_range(0, 12'h0DF); r = $urandom_range(0, 12'h0DF); end
      if (kind == 3) begin l = $urandom_range(12'h0E0, 12'h120); r = 512 - l + $urandom_range(0, 12'h040); end
      for (int c = 0; c < len; c++) begin
        if (kind == 1 || kind == 4) begin
          l = $urandom_range(0, 12'hFFF) >> $urandom_range(0, 4);
          r = $urandom_range(0, 12'hFFF) >> $urandom_range(0, 4);
        end
        if (kind == 5) begin
          l = ($urandom_range(0, 7) == 0) ? 12'h0C0 : 12'h180;
          r = l;
        end
        step(l, r);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
